// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a synchronous instruction ROM and presents the decoded
// fields of the fetched instruction. It tracks whether the ROM data is on the
// live path, and it squashes wrong-path fetches after a redirect with NOP bubbles.
module fetch_stage #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 20,
  parameter logic [3:0]  NOP_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [3:0]         id_opcode,
  output logic [3:0]         id_rd,
  output logic [3:0]         id_ra,
  output logic [3:0]         id_rb,
  output logic [7:0]         id_imm
);

  // BOOT: ROM data not yet valid; RUN: ROM data is the instruction at fetch_pc;
  // REDIRECT: ROM data was fetched on the wrong path.
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic              load_instr;
  logic              load_bubble;

  // The ROM is frozen while stalled so its output survives the stall.
  // A redirect overrides the stall.
  assign imem_en   = ~stall | branch_taken;
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: redirect beats stall, stall freezes the state
  always_comb begin
    state_next = state;
    if (branch_taken) begin
      state_next = REDIRECT;
    end else if (!stall) begin
      state_next = RUN;
    end
  end

  // Output/control logic: PC update and IF/ID load selection
  always_comb begin
    pc_next       = pc;
    fetch_pc_next = fetch_pc;
    load_instr    = 1'b0;
    load_bubble   = 1'b0;
    if (branch_taken) begin
      pc_next     = branch_target;
      load_bubble = 1'b1;
    end else if (!stall) begin
      pc_next       = pc + ADDR_W'(1);
      fetch_pc_next = pc;
      if (state == RUN) begin
        load_instr = 1'b1;
      end else begin
        load_bubble = 1'b1;
      end
    end
  end

  // PC and address-of-ROM-data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      fetch_pc <= '0;
    end else begin
      pc       <= pc_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // IF/ID register; bubbles zero the fields so the NOP decodes to no register or memory enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_opcode <= NOP_OP;
      id_rd     <= 4'h0;
      id_ra     <= 4'h0;
      id_rb     <= 4'h0;
      id_imm    <= 8'h00;
    end else if (load_instr) begin
      id_valid  <= 1'b1;
      id_pc     <= fetch_pc;
      id_opcode <= imem_rdata[19:16];
      id_rd     <= imem_rdata[15:12];
      id_ra     <= imem_rdata[11:8];
      id_rb     <= imem_rdata[7:4];
      id_imm    <= imem_rdata[7:0];
    end else if (load_bubble) begin
      id_valid  <= 1'b0;
      id_opcode <= NOP_OP;
      id_rd     <= 4'h0;
      id_ra     <= 4'h0;
      id_rb     <= 4'h0;
      id_imm    <= 8'h00;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a synchronous ROM model.
module tb_fetch_stage;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned INSTR_W = 20;
  localparam int unsigned NVEC    = 30;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_pc;
  logic [3:0]         id_opcode;
  logic [3:0]         id_rd;
  logic [3:0]         id_ra;
  logic [3:0]         id_rb;
  logic [7:0]         id_imm;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_rd         (id_rd),
    .id_ra         (id_ra),
    .id_rb         (id_rb),
    .id_imm        (id_imm)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: output holds while imem_en is low
  logic [INSTR_W-1:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  typedef struct {
    logic              stall;
    logic              bt;
    logic [ADDR_W-1:0] target;
    logic              exp_en;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_id_pc;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vecs [NVEC];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_id(input logic exp_valid, input logic [ADDR_W-1:0] exp_pc);
    logic [INSTR_W-1:0] w;
    chk("id_valid", 32'(id_valid), 32'(exp_valid));
    if (exp_valid) begin
      w = rom[exp_pc];
      chk("id_pc",     32'(id_pc),     32'(exp_pc));
      chk("id_opcode", 32'(id_opcode), 32'(w[19:16]));
      chk("id_rd",     32'(id_rd),     32'(w[15:12]));
      chk("id_ra",     32'(id_ra),     32'(w[11:8]));
      chk("id_rb",     32'(id_rb),     32'(w[7:4]));
      chk("id_imm",    32'(id_imm),    32'(w[7:0]));
    end else begin
      chk("bubble_opcode", 32'(id_opcode), 32'h0000_000F);
      chk("bubble_fields", {20'(0), id_rd, id_ra, id_rb}, 32'h0);
      chk("bubble_imm",    32'(id_imm),    32'h0);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_addr",   32'(imem_addr), 32'h0);
    chk("rst_id_pc",  32'(id_pc),     32'h0);
    chk("rst_en",     32'(imem_en),   32'h1);
    check_id(1'b0, '0);
  endtask

  // Drive one vector just after a sample point, then sample 1 after the next rising edge
  task automatic apply_vec(input int i);
    stall         = vecs[i].stall;
    branch_taken  = vecs[i].bt;
    branch_target = vecs[i].target;
    #1;
    chk($sformatf("v%0d_imem_en", i), 32'(imem_en), 32'(vecs[i].exp_en));
    @(posedge clk);
    #1;
    check_id(vecs[i].exp_valid, vecs[i].exp_id_pc);
    chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
  endtask

  initial begin
    //          stall bt  target  en valid id_pc   addr
    vecs[0]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h001};
    vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 10'h002};
    vecs[2]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h001, 10'h003};
    vecs[3]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 10'h003};
    vecs[4]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 10'h003};
    vecs[5]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 10'h003};
    vecs[6]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h002, 10'h004};
    vecs[7]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h003, 10'h005};
    vecs[8]  = '{1'b0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h000, 10'h040};
    vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h041};
    vecs[10] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 10'h042};
    vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h041, 10'h043};
    vecs[12] = '{1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0, 10'h000, 10'h3FF};
    vecs[13] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h000};
    vecs[14] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 10'h001};
    vecs[15] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 10'h002};
    vecs[16] = '{1'b0, 1'b1, 10'h010, 1'b1, 1'b0, 10'h000, 10'h010};
    vecs[17] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 10'h010};
    vecs[18] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 10'h010};
    vecs[19] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h011};
    vecs[20] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 10'h012};
    vecs[21] = '{1'b0, 1'b1, 10'h020, 1'b1, 1'b0, 10'h000, 10'h020};
    vecs[22] = '{1'b0, 1'b1, 10'h030, 1'b1, 1'b0, 10'h000, 10'h030};
    vecs[23] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h031};
    vecs[24] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h030, 10'h032};
    vecs[25] = '{1'b0, 1'b1, 10'h005, 1'b1, 1'b0, 10'h000, 10'h005};
    vecs[26] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h006};
    vecs[27] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h005, 10'h007};
    vecs[28] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h006, 10'h008};
    vecs[29] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h007, 10'h009};

    for (int a = 0; a < (1 << ADDR_W); a++) begin
      logic [ADDR_W-1:0] aa;
      aa = ADDR_W'(a);
      rom[a] = {aa[3:0] ^ 4'h5, aa[7:4], ~aa[3:0], 8'(a * 3)};
    end
    rom[0] = 20'h1_1230;
    rom[1] = 20'h2_4560;
    rom[2] = 20'h3_7890;
    rom[3] = 20'hF_0000;

    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) apply_vec(i);

    // Asynchronous reset in the middle of a clock-high phase with id_pc == 7
    stall        = 1'b0;
    branch_taken = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // Restart from address 0 exactly as after the first reset
    for (int i = 0; i < 3; i++) apply_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
